seg7_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment display controller, successor to the fixed 4-digit hex scanner. Scans NUM_DIGITS common-anode digits from one sclk-domain register and decodes each 4-bit nibble to hex glyphs. Adds a load handshake with frame-aligned double buffering, leading-zero blanking and PWM brightness. Sits between any data producer and the board's anode/segment pins.

---
 rtl/seg7_pkg.sv | 46 ++++
 rtl/seg7_scan_ctrl_if.sv | 40 ++++
 rtl/seg7_hex_decode.sv | 40 ++++
 rtl/seg7_scan_ctrl.sv | 178 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared glyph constants and helpers for seven-segment display blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  typedef logic [6:0] seg_t;

  // Bit positions inside a seg_t, abcdefg order with 'a' in the MSB.
  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;
  localparam seg_t SEG_BLANK = 7'b0000000;

  // All-ones anode word for up to 8 digits; callers slice the low 'width' bits.
  function automatic logic [7:0] ANODES_OFF(input int width);
    ANODES_OFF = 8'hFF >> (8 - width);
  endfunction

endpackage : seg7_pkg

`default_nettype wire

// File: rtl/seg7_scan_ctrl_if.sv
// ============================================================================
// Module   : seg7_scan_ctrl_if
// Brief    : Load handshake between a data producer and seg7_scan_ctrl.
//            Macro SEG7_DP_EN adds the per-digit decimal-point mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] data_in;
  logic                    data_load;
  logic                    data_pending;
`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0]   dp_mask;
`endif

  modport master (
`ifdef SEG7_DP_EN
    output dp_mask,
`endif
    output data_in,
    output data_load,
    input  data_pending
  );

  modport slave (
`ifdef SEG7_DP_EN
    input  dp_mask,
`endif
    input  data_in,
    input  data_load,
    output data_pending
  );

endinterface : seg7_scan_ctrl_if

`default_nettype wire

// File: rtl/seg7_hex_decode.sv
// ============================================================================
// Module   : seg7_hex_decode
// Brief    : Combinational nibble to abcdefg hex glyph decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_hex_decode
  import seg7_pkg::*;
(
  input  wire  [3:0] nibble_i,
  output seg_t       glyph_o
);

  always_comb begin
    glyph_o = SEG_BLANK;
    case (nibble_i)
      4'h0: glyph_o = SEG_0;
      4'h1: glyph_o = SEG_1;
      4'h2: glyph_o = SEG_2;
      4'h3: glyph_o = SEG_3;
      4'h4: glyph_o = SEG_4;
      4'h5: glyph_o = SEG_5;
      4'h6: glyph_o = SEG_6;
      4'h7: glyph_o = SEG_7;
      4'h8: glyph_o = SEG_8;
      4'h9: glyph_o = SEG_9;
      4'hA: glyph_o = SEG_A;
      4'hB: glyph_o = SEG_B;
      4'hC: glyph_o = SEG_C;
      4'hD: glyph_o = SEG_D;
      4'hE: glyph_o = SEG_E;
      4'hF: glyph_o = SEG_F;
      default: glyph_o = SEG_BLANK;
    endcase
  end

endmodule : seg7_hex_decode

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : Multiplexed common-anode hex display scanner with frame-aligned
//            double buffering, leading-zero blanking and PWM brightness.
//            Macro SEG7_DP_EN adds decimal-point mask input and dp output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 200000,
  parameter int BRIGHT_W   = 3
) (
  input  wire                    sclk,
  input  wire                    rst,
  seg7_scan_ctrl_if.slave        bus,
  input  wire                    blank_lz,
  input  wire  [BRIGHT_W-1:0]    brightness,
  output logic                   frame_tick,
  output logic [NUM_DIGITS-1:0]  indikators,
`ifdef SEG7_DP_EN
  output logic                   dp,
`endif
  output logic [6:0]             segments
);

  localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int K_W     = $clog2(NUM_DIGITS);
  localparam int SLOT_ON = DIV >> BRIGHT_W;
  localparam logic [7:0]            C_OFF8 = ANODES_OFF(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] C_OFF  = C_OFF8[NUM_DIGITS-1:0];

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   indikators_q, indikators_d;
  seg_t                    segments_q, segments_d;

  logic                    w_last_slot;
  logic                    w_frame_end;
  int                      w_digit_idx;
  logic [3:0]              w_nibble;
  seg_t                    w_glyph;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_blank;
  logic [31:0]             w_on_limit;
  logic                    w_on;

  assign w_last_slot = (cnt_q == CNT_W'(DIV - 1));
  assign w_frame_end = w_last_slot && (k_q == K_W'(NUM_DIGITS - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    k_d   = k_q;
    if (w_last_slot) begin
      cnt_d = '0;
      k_d   = (k_q == K_W'(NUM_DIGITS - 1)) ? '0 : k_q + K_W'(1);
    end
  end

  // Display data only changes on the frame boundary so a frame never tears;
  // a load landing exactly on that boundary goes straight to the display.
  always_comb begin
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (w_frame_end) begin
      if (bus.data_load) begin
        disp_d = bus.data_in;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (bus.data_load) begin
      shadow_d  = bus.data_in;
      pending_d = 1'b1;
    end
  end

  assign w_digit_idx = NUM_DIGITS - 1 - int'(k_q);
  assign w_nibble    = disp_q[4*w_digit_idx +: 4];

  seg7_hex_decode u_dec (
    .nibble_i (w_nibble),
    .glyph_o  (w_glyph)
  );

  // w_lz[j] is set when digit j and every digit left of it hold zero.
  always_comb begin
    logic run;
    run  = 1'b1;
    w_lz = '0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      run     = run & (disp_q[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
      w_lz[j] = run;
    end
  end

  assign w_blank    = blank_lz && (k_q != K_W'(NUM_DIGITS - 1)) && w_lz[k_q];
  assign w_on_limit = (32'(brightness) + 32'd1) * 32'(SLOT_ON);
  assign w_on       = 32'(cnt_q) < w_on_limit;

  always_comb begin
    indikators_d = C_OFF;
    if (w_on) begin
      indikators_d[w_digit_idx] = 1'b0;
    end
    segments_d = w_blank ? SEG_BLANK : w_glyph;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      cnt_q        <= '0;
      k_q          <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      indikators_q <= C_OFF;
      segments_q   <= SEG_BLANK;
    end else begin
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      indikators_q <= indikators_d;
      segments_q   <= segments_d;
    end
  end

`ifdef SEG7_DP_EN
  logic [NUM_DIGITS-1:0] dp_shadow_q, dp_shadow_d;
  logic [NUM_DIGITS-1:0] dp_disp_q, dp_disp_d;
  logic                  dp_q, dp_d;

  always_comb begin
    dp_shadow_d = dp_shadow_q;
    dp_disp_d   = dp_disp_q;
    if (w_frame_end) begin
      if (bus.data_load) begin
        dp_disp_d = bus.dp_mask;
      end else if (pending_q) begin
        dp_disp_d = dp_shadow_q;
      end
    end else if (bus.data_load) begin
      dp_shadow_d = bus.dp_mask;
    end
    dp_d = w_on && dp_disp_q[w_digit_idx];
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      dp_shadow_q <= '0;
      dp_disp_q   <= '0;
      dp_q        <= 1'b0;
    end else begin
      dp_shadow_q <= dp_shadow_d;
      dp_disp_q   <= dp_disp_d;
      dp_q        <= dp_d;
    end
  end

  assign dp = dp_q;
`endif

  assign bus.data_pending = pending_q;
  assign frame_tick       = w_frame_end;
  assign indikators       = indikators_q;
  assign segments         = segments_q;

endmodule : seg7_scan_ctrl

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Brief    : Directed self-checking bench for seg7_scan_ctrl (4 digits, DIV=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G1 = 7'b0110000;
  localparam logic [6:0] G2 = 7'b1101101;
  localparam logic [6:0] G3 = 7'b1111001;
  localparam logic [6:0] G5 = 7'b1011011;
  localparam logic [6:0] GA = 7'b1110111;
  localparam logic [6:0] GF = 7'b1000111;
  localparam logic [6:0] GB = 7'b0000000;

  logic       sclk = 1'b0;
  logic       rst;
  logic       blank_lz;
  logic [1:0] brightness;
  logic       frame_tick;
  logic [3:0] indikators;
  logic [6:0] segments;
`ifdef SEG7_DP_EN
  logic       dp;
  logic [3:0] exp_dpm;
`endif

  int tests = 0;
  int fails = 0;

  seg7_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS (4),
    .DIV        (8),
    .BRIGHT_W   (2)
  ) dut (
    .sclk       (sclk),
    .rst        (rst),
    .bus        (bus),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .frame_tick (frame_tick),
    .indikators (indikators),
`ifdef SEG7_DP_EN
    .dp         (dp),
`endif
    .segments   (segments)
  );

  always #5 sclk = ~sclk;

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] d);
    bus.data_in   = d;
    bus.data_load = 1'b1;
    step();
    bus.data_load = 1'b0;
  endtask

  // Steps until frame_tick is seen (at least one step); n = steps taken.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_tick && n < 100);
    chk("frame_tick_seen", {31'd0, frame_tick}, 32'd1);
  endtask

  // Checks one whole frame starting at cnt=0,k=0 (outputs lag state by one).
  task automatic check_frame(input logic [6:0] g0, input logic [6:0] g1,
                             input logic [6:0] g2, input logic [6:0] g3,
                             input int b);
    logic [6:0] g [4];
    logic       on;
    logic [3:0] exp_ind;
    g = '{g0, g1, g2, g3};
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        on      = (c < (b + 1) * 2);
        exp_ind = on ? ~(4'b1000 >> s) : 4'hF;
        chk($sformatf("anode d%0d c%0d", s, c), {28'd0, indikators}, {28'd0, exp_ind});
        chk($sformatf("seg d%0d c%0d", s, c), {25'd0, segments}, {25'd0, g[s]});
`ifdef SEG7_DP_EN
        chk($sformatf("dp d%0d c%0d", s, c), {31'd0, dp}, {31'd0, on && exp_dpm[3-s]});
`endif
      end
    end
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    blank_lz      = 1'b0;
    brightness    = 2'd3;
    bus.data_in   = '0;
    bus.data_load = 1'b0;
`ifdef SEG7_DP_EN
    bus.dp_mask   = '0;
    exp_dpm       = '0;
`endif

    // Reset
    repeat (3) step();
    chk("rst_ind", {28'd0, indikators}, 32'hF);
    chk("rst_seg", {25'd0, segments}, 32'h0);
    chk("rst_pending", {31'd0, bus.data_pending}, 32'd0);
    chk("rst_tick", {31'd0, frame_tick}, 32'd0);
    rst = 1'b0;

    // Load and scan 12AF
    load(16'h12AF);
    chk("pend_after_load", {31'd0, bus.data_pending}, 32'd1);
    wait_tick(n);
    chk("pend_at_tick", {31'd0, bus.data_pending}, 32'd1);
    step();
    chk("pend_after_commit", {31'd0, bus.data_pending}, 32'd0);
    check_frame(G1, G2, GA, GF, 3);

    // Leading-zero blanking
    blank_lz = 1'b1;
    load(16'h0005);
    wait_tick(n);
    step();
    check_frame(GB, GB, GB, G5, 3);
    load(16'h0000);
    wait_tick(n);
    step();
    check_frame(GB, GB, GB, G0, 3);

    // Frame period
    wait_tick(n);
    wait_tick(n);
    chk("frame_period", n, 32'd32);

    // Brightness
    blank_lz   = 1'b0;
    brightness = 2'd0;
    step();
    check_frame(G0, G0, G0, G0, 0);
    brightness = 2'd2;
    check_frame(G0, G0, G0, G0, 2);

    // Two loads in one frame: last wins
    brightness = 2'd3;
    load(16'h1111);
    repeat (3) step();
    load(16'h2222);
    chk("pend_double", {31'd0, bus.data_pending}, 32'd1);
    wait_tick(n);
    step();
    check_frame(G2, G2, G2, G2, 3);

    // Load on the frame_tick cycle bypasses the shadow
    wait_tick(n);
    load(16'h3333);
    chk("pend_bypass", {31'd0, bus.data_pending}, 32'd0);
    check_frame(G3, G3, G3, G3, 3);

    // Reset mid-frame with pending data
    load(16'h4444);
    chk("pend_before_rst", {31'd0, bus.data_pending}, 32'd1);
    repeat (18) step();
    rst = 1'b1;
    step();
    chk("mid_rst_ind", {28'd0, indikators}, 32'hF);
    chk("mid_rst_seg", {25'd0, segments}, 32'h0);
    chk("mid_rst_pending", {31'd0, bus.data_pending}, 32'd0);
    chk("mid_rst_tick", {31'd0, frame_tick}, 32'd0);
    rst = 1'b0;
    check_frame(G0, G0, G0, G0, 3);
    wait_tick(n);
    chk("pend_discarded", {31'd0, bus.data_pending}, 32'd0);
    step();
    check_frame(G0, G0, G0, G0, 3);

`ifdef SEG7_DP_EN
    // Decimal point on digit 1 only
    bus.dp_mask = 4'b0100;
    load(16'h0000);
    wait_tick(n);
    step();
    exp_dpm = 4'b0100;
    check_frame(G0, G0, G0, G0, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_seg7_scan_ctrl

`default_nettype wire
